// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The master drives the request and address; the slave answers with ack and data.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per step over a req/ack
// bus, holds it for the decoder and computes the next PC on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master imem,
    output logic [31:0]  inst,
    output logic         inst_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pc4,
    input  logic [1:0]   npc_op,
    input  logic         br_taken,
    input  logic [31:0]  imm,
    input  logic [31:0]  alu_c,
    input  logic         retire,
    output logic         fault
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [1:0] OP_SEQ    = 2'b00;
    localparam logic [1:0] OP_JALR   = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_JAL    = 2'b11;

    state_t      state_reg,  state_next;
    logic [31:0] pc_reg,     pc_next;
    logic [31:0] inst_reg,   inst_next;
    logic        valid_reg,  valid_next;
    logic        req_reg,    req_next;
    logic        fault_reg,  fault_next;

    logic [31:0] seq_pc;
    logic [31:0] rel_pc;
    logic [31:0] npc;

    assign seq_pc = pc_reg + 32'd4;
    assign rel_pc = pc_reg + imm;

    always_comb begin
        npc = seq_pc;
        case (npc_op)
            OP_SEQ:    npc = seq_pc;
            OP_JALR:   npc = alu_c & 32'hFFFF_FFFE;
            OP_BRANCH: npc = br_taken ? rel_pc : seq_pc;
            OP_JAL:    npc = rel_pc;
            default:   npc = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_REQ;
            pc_reg    <= RESET_PC;
            inst_reg  <= NOP_INST;
            valid_reg <= 1'b0;
            req_reg   <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
            valid_reg <= valid_next;
            req_reg   <= req_next;
            fault_reg <= fault_next;
        end
    end

    // Ack is only honoured in WAIT and retire only in EXEC, so the two never collide.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        valid_next = valid_reg;
        req_next   = req_reg;
        fault_next = fault_reg;
        case (state_reg)
            ST_REQ: begin
                req_next   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem.imem_ack) begin
                    inst_next  = imem.imem_rdata;
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (retire) begin
                    valid_next = 1'b0;
                    if (npc[1:0] == 2'b00) begin
                        pc_next    = npc;
                        state_next = ST_REQ;
                    end else begin
                        fault_next = 1'b1;
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                req_next = 1'b0;
            end
            default: begin
                state_next = ST_HALT;
                req_next   = 1'b0;
            end
        endcase
    end

    // The PC never moves while a request is outstanding, so it doubles as the address.
    assign imem.imem_req  = req_reg;
    assign imem.imem_addr = pc_reg;

    assign inst       = inst_reg;
    assign inst_valid = valid_reg;
    assign pc         = pc_reg;
    assign pc4        = seq_pc;
    assign fault      = fault_reg;

endmodule
